// File: rtl/join_core_stage_param.sv
// join_core_stage_param
// One cell of the stream-join systolic chain. Holds a resident stream tuple
// and a passing window tuple, evaluates the configured join predicate and
// parks matches in a small local FIFO. The FIFO only drains into the result
// chain when the upstream result slot is idle and the downstream is not
// stalling, so window flow is decoupled from result-chain occupancy until
// the FIFO fills.
module join_core_stage_param #(
  parameter int KEY_WIDTH   = 32,
  parameter int ID_WIDTH    = 31,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16,
  localparam int TW         = 1 + ID_WIDTH + KEY_WIDTH,
  localparam int RW         = 1 + 2 * ID_WIDTH,
  localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [1:0]             mode_cfg,
  input  logic [KEY_WIDTH-1:0]   band_cfg,
  input  logic                   stream_full_in,
  output logic                   stream_full_out,
  input  logic                   stream_clear_in,
  output logic                   stream_clear_out,
  input  logic [TW-1:0]          stream_tuple_in,
  output logic [TW-1:0]          stream_tuple_out,
  input  logic                   window_full_in,
  output logic                   window_full_out,
  input  logic [TW-1:0]          window_tuple_in,
  output logic [TW-1:0]          window_tuple_out,
  input  logic [RW-1:0]          result_pair_in,
  output logic [RW-1:0]          result_pair_out,
  input  logic                   result_stall_in,
  output logic                   result_stall_out,
  output logic [PTR_WIDTH-1:0]   fifo_count,
  output logic [COUNT_WIDTH-1:0] match_count
);

  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] DEPTH_L = PTR_WIDTH'(FIFO_DEPTH);

  // Mode encodings for the predicate selector
  localparam logic [1:0] MODE_EQUI = 2'd0;
  localparam logic [1:0] MODE_BAND = 2'd1;
  localparam logic [1:0] MODE_LT   = 2'd2;

  // State
  logic [TW-1:0]          stream_reg;
  logic [TW-1:0]          window_reg;
  logic                   clear_reg;
  logic                   stall_reg;
  logic                   done;
  logic [RW-1:0]          result_reg;
  logic [2*ID_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [COUNT_WIDTH-1:0] match_cnt;

  // Decoded tuple fields
  logic                 s_valid;
  logic                 w_valid;
  logic [ID_WIDTH-1:0]  s_id;
  logic [ID_WIDTH-1:0]  w_id;
  logic [KEY_WIDTH-1:0] s_key;
  logic [KEY_WIDTH-1:0] w_key;

  assign s_valid = stream_reg[TW-1];
  assign s_id    = stream_reg[TW-2 -: ID_WIDTH];
  assign s_key   = stream_reg[KEY_WIDTH-1:0];
  assign w_valid = window_reg[TW-1];
  assign w_id    = window_reg[TW-2 -: ID_WIDTH];
  assign w_key   = window_reg[KEY_WIDTH-1:0];

  // Combinational control
  logic [KEY_WIDTH:0]   key_diff;
  logic [KEY_WIDTH:0]   abs_diff;
  logic                 pred_hit;
  logic                 match;
  logic                 push;
  logic                 pop;
  logic                 flow;
  logic                 fifo_empty;
  logic [PTR_WIDTH-1:0] occupancy;

  assign occupancy  = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);

  // Predicate: band distance is taken one bit wider so the sign survives
  always_comb begin
    key_diff = {1'b0, s_key} - {1'b0, w_key};
    abs_diff = key_diff;
    if (key_diff[KEY_WIDTH]) begin
      abs_diff = ~key_diff + {{KEY_WIDTH{1'b0}}, 1'b1};
    end
    pred_hit = 1'b0;
    case (mode_cfg)
      MODE_EQUI: pred_hit = (s_key == w_key);
      MODE_BAND: pred_hit = (abs_diff <= {1'b0, band_cfg});
      MODE_LT:   pred_hit = (s_key < w_key);
      default:   pred_hit = 1'b0;
    endcase
  end

  // Match, enqueue, window flow and FIFO drain decisions
  always_comb begin
    match = s_valid & w_valid & ~done & pred_hit;
    push  = match & (occupancy < DEPTH_L);
    flow  = w_valid & ~window_full_in & (~match | push);
    pop   = ~result_pair_in[RW-1] & ~fifo_empty & ~stall_reg;
  end

  // Registered copies of the clear request and downstream stall
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      clear_reg <= 1'b0;
      stall_reg <= 1'b0;
    end else begin
      clear_reg <= stream_clear_in;
      stall_reg <= result_stall_in;
    end
  end

  // Stream register: clear, hand off downstream, or load when empty
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stream_reg <= '0;
    end else if (clear_reg) begin
      stream_reg <= '0;
    end else if (s_valid && !stream_full_in) begin
      stream_reg <= '0;
    end else if (!s_valid && stream_tuple_in[TW-1]) begin
      stream_reg <= stream_tuple_in;
    end
  end

  // Window register: refill when empty or when the resident tuple leaves
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      window_reg <= '0;
    end else if (!w_valid || flow) begin
      window_reg <= window_tuple_in[TW-1] ? window_tuple_in : '0;
    end
  end

  // done marks a resident window whose result is already queued; a clear
  // drops it so the tuple is re-evaluated against the next stream tuple
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done <= 1'b0;
    end else if (clear_reg || flow) begin
      done <= 1'b0;
    end else if (push) begin
      done <= 1'b1;
    end
  end

  // FIFO pointers; fullness is judged before any same-cycle pop
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_id, w_id};
    end
  end

  // Result register: upstream results win, otherwise drain the FIFO head
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      result_reg <= '0;
    end else if (result_pair_in[RW-1]) begin
      result_reg <= result_pair_in;
    end else if (pop) begin
      result_reg <= {1'b1, fifo_mem[rd_ptr[ADDR_WIDTH-1:0]]};
    end else begin
      result_reg <= '0;
    end
  end

  // Saturating count of enqueued matches, reset by a stream clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      match_cnt <= '0;
    end else if (clear_reg) begin
      match_cnt <= '0;
    end else if (push && !(&match_cnt)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

  assign stream_full_out  = s_valid;
  assign stream_clear_out = clear_reg;
  assign stream_tuple_out = stream_reg;
  assign window_full_out  = w_valid;
  assign window_tuple_out = flow ? window_reg : '0;
  assign result_pair_out  = result_reg;
  assign result_stall_out = stall_reg;
  assign fifo_count       = occupancy;
  assign match_count      = match_cnt;

endmodule

// File: tb/tb_join_core_stage_param.sv
// tb_join_core_stage_param
// Directed bench for join_core_stage_param with default parameters:
// a vector table for the predicate modes plus hand-written sequences for
// FIFO-full, stall, clear and reset behaviour.
module tb_join_core_stage_param;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  mode_cfg;
  logic [31:0] band_cfg;
  logic        stream_full_in;
  logic        stream_full_out;
  logic        stream_clear_in;
  logic        stream_clear_out;
  logic [63:0] stream_tuple_in;
  logic [63:0] stream_tuple_out;
  logic        window_full_in;
  logic        window_full_out;
  logic [63:0] window_tuple_in;
  logic [63:0] window_tuple_out;
  logic [62:0] result_pair_in;
  logic [62:0] result_pair_out;
  logic        result_stall_in;
  logic        result_stall_out;
  logic [2:0]  fifo_count;
  logic [15:0] match_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] band;
    logic [63:0] s_in;
    logic        clr;
    logic [63:0] w_in;
    logic        w_full_in;
    logic [62:0] r_in;
    logic        stall;
    logic [62:0] exp_result;
    logic [2:0]  exp_fifo;
    logic [15:0] exp_mcount;
    logic        exp_sfull;
    logic        exp_wfull;
    logic        exp_wflow;
    logic        exp_clr;
  } vec_t;

  vec_t table_v[15];
  vec_t seq_v[8];

  join_core_stage_param dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .mode_cfg         (mode_cfg),
    .band_cfg         (band_cfg),
    .stream_full_in   (stream_full_in),
    .stream_full_out  (stream_full_out),
    .stream_clear_in  (stream_clear_in),
    .stream_clear_out (stream_clear_out),
    .stream_tuple_in  (stream_tuple_in),
    .stream_tuple_out (stream_tuple_out),
    .window_full_in   (window_full_in),
    .window_full_out  (window_full_out),
    .window_tuple_in  (window_tuple_in),
    .window_tuple_out (window_tuple_out),
    .result_pair_in   (result_pair_in),
    .result_pair_out  (result_pair_out),
    .result_stall_in  (result_stall_in),
    .result_stall_out (result_stall_out),
    .fifo_count       (fifo_count),
    .match_count      (match_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 aclk = ~aclk;

  function automatic logic [63:0] tup(input int id, input int key);
    return {1'b1, id[30:0], key[31:0]};
  endfunction

  function automatic logic [62:0] res(input int sid, input int wid);
    return {1'b1, sid[30:0], wid[30:0]};
  endfunction

  function automatic vec_t mk(
    input logic [1:0] mode, input logic [31:0] band, input logic [63:0] s,
    input logic clr, input logic [63:0] w, input logic wfin,
    input logic [62:0] r, input logic stall, input logic [62:0] er,
    input logic [2:0] ef, input logic [15:0] em, input logic esf,
    input logic ewf, input logic ewfl, input logic ecl);
    vec_t v;
    v.mode = mode; v.band = band; v.s_in = s; v.clr = clr; v.w_in = w;
    v.w_full_in = wfin; v.r_in = r; v.stall = stall; v.exp_result = er;
    v.exp_fifo = ef; v.exp_mcount = em; v.exp_sfull = esf;
    v.exp_wfull = ewf; v.exp_wflow = ewfl; v.exp_clr = ecl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample half a step after the edge
  task automatic applyStimulus(input vec_t v);
    mode_cfg        = v.mode;
    band_cfg        = v.band;
    stream_tuple_in = v.s_in;
    stream_clear_in = v.clr;
    window_tuple_in = v.w_in;
    window_full_in  = v.w_full_in;
    result_pair_in  = v.r_in;
    result_stall_in = v.stall;
    @(posedge aclk);
    #1;
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput({tag, ".result"}, 64'(result_pair_out), 64'(v.exp_result));
    checkOutput({tag, ".fifo"},   64'(fifo_count),      64'(v.exp_fifo));
    checkOutput({tag, ".mcount"}, 64'(match_count),     64'(v.exp_mcount));
    checkOutput({tag, ".sfull"},  64'(stream_full_out), 64'(v.exp_sfull));
    checkOutput({tag, ".wfull"},  64'(window_full_out), 64'(v.exp_wfull));
    checkOutput({tag, ".wflow"},  64'(window_tuple_out[63]), 64'(v.exp_wflow));
    checkOutput({tag, ".clr"},    64'(stream_clear_out), 64'(v.exp_clr));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".result"}, 64'(result_pair_out), 64'd0);
    checkOutput({tag, ".fifo"},   64'(fifo_count), 64'd0);
    checkOutput({tag, ".mcount"}, 64'(match_count), 64'd0);
    checkOutput({tag, ".flags"},
                64'({stream_full_out, window_full_out, stream_clear_out,
                     result_stall_out}), 64'd0);
    checkOutput({tag, ".stuple"}, stream_tuple_out, 64'd0);
    checkOutput({tag, ".wtuple"}, window_tuple_out, 64'd0);
  endtask

  task automatic idleInputs();
    stream_tuple_in = '0;
    stream_clear_in = 1'b0;
    window_tuple_in = '0;
    window_full_in  = 1'b0;
    result_pair_in  = '0;
    result_stall_in = 1'b0;
  endtask

  // Safety net against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    logic [62:0] rx[$];
    int sent;
    int max_fifo;
    bit stall_seen;

    aresetn        = 1'b0;
    mode_cfg       = 2'd0;
    band_cfg       = '0;
    stream_full_in = 1'b1;
    idleInputs();

    // Predicate table: equi, then band 3 around key 100, then less-than/disabled
    table_v[0]  = mk(2'd0, 32'd0, tup(5, 16), 1'b0, tup(9, 16), 1'b0, '0, 1'b0, '0, 3'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    table_v[1]  = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 3'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    table_v[2]  = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, '0, 1'b0, res(5, 9), 3'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    table_v[3]  = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 3'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    table_v[4]  = mk(2'd1, 32'd3, '0, 1'b1, '0, 1'b0, '0, 1'b0, '0, 3'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    table_v[5]  = mk(2'd1, 32'd3, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    table_v[6]  = mk(2'd1, 32'd3, tup(7, 100), 1'b0, tup(20, 97), 1'b0, '0, 1'b0, '0, 3'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    table_v[7]  = mk(2'd1, 32'd3, '0, 1'b0, tup(21, 103), 1'b0, '0, 1'b0, '0, 3'd1, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    table_v[8]  = mk(2'd1, 32'd3, '0, 1'b0, tup(22, 104), 1'b0, '0, 1'b0, res(7, 20), 3'd1, 16'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    table_v[9]  = mk(2'd1, 32'd3, '0, 1'b0, '0, 1'b0, '0, 1'b0, res(7, 21), 3'd0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    table_v[10] = mk(2'd1, 32'd3, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 3'd0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    table_v[11] = mk(2'd2, 32'd3, '0, 1'b0, tup(23, 101), 1'b0, '0, 1'b0, '0, 3'd0, 16'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    table_v[12] = mk(2'd2, 32'd3, '0, 1'b0, tup(24, 100), 1'b0, '0, 1'b0, '0, 3'd1, 16'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    table_v[13] = mk(2'd3, 32'd3, '0, 1'b0, tup(25, 100), 1'b0, '0, 1'b0, res(7, 23), 3'd0, 16'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    table_v[14] = mk(2'd3, 32'd3, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 3'd0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state, checked while reset is still asserted
    #12;
    checkAllZero("reset");
    #10;
    aresetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(table_v[i]);
      checkVector($sformatf("vec%0d", i), table_v[i]);
    end

    // FIFO full: upstream results occupy the slot for 10 cycles while six
    // matching windows (key 100 against stream 7/100) arrive
    idleInputs();
    mode_cfg   = 2'd0;
    sent       = 0;
    max_fifo   = 0;
    stall_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      result_pair_in = (c < 10) ? res(60 + c, 70 + c) : '0;
      if (sent < 6 && (!window_full_out || window_tuple_out[63])) begin
        window_tuple_in = tup(30 + sent, 100);
        sent++;
      end else begin
        window_tuple_in = '0;
      end
      @(posedge aclk);
      #1;
      if (c < 10) begin
        checkOutput($sformatf("full.fwd%0d", c), 64'(result_pair_out), 64'(res(60 + c, 70 + c)));
      end else if (result_pair_out[62]) begin
        rx.push_back(result_pair_out);
      end
      if (int'(fifo_count) > max_fifo) max_fifo = int'(fifo_count);
      if (fifo_count == 3'd4 && window_full_out && !window_tuple_out[63]) stall_seen = 1'b1;
    end
    checkOutput("full.max_fifo", 64'(max_fifo), 64'd4);
    checkOutput("full.window_held", 64'(stall_seen), 64'd1);
    checkOutput("full.result_count", 64'(rx.size()), 64'd6);
    for (int i = 0; i < rx.size() && i < 6; i++) begin
      checkOutput($sformatf("full.order%0d", i), 64'(rx[i]), 64'(res(7, 30 + i)));
    end
    checkOutput("full.mcount", 64'(match_count), 64'd9);
    checkOutput("full.drained", 64'(fifo_count), 64'd0);

    // Stall: two entries queued behind upstream traffic, stall for 3 cycles
    seq_v[0] = mk(2'd0, 32'd0, '0, 1'b0, tup(40, 100), 1'b0, res(80, 81), 1'b0, res(80, 81), 3'd0, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    seq_v[1] = mk(2'd0, 32'd0, '0, 1'b0, tup(41, 100), 1'b0, res(82, 83), 1'b0, res(82, 83), 3'd1, 16'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    seq_v[2] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, res(84, 85), 1'b1, res(84, 85), 3'd2, 16'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_v[3] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, res(86, 87), 1'b1, res(86, 87), 3'd2, 16'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_v[4] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, '0, 1'b1, '0, 3'd2, 16'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_v[5] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 3'd2, 16'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_v[6] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, '0, 1'b0, res(7, 40), 3'd1, 16'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    seq_v[7] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, '0, 1'b0, res(7, 41), 3'd0, 16'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(seq_v[i]);
      checkVector($sformatf("stall%0d", i), seq_v[i]);
      if (i == 2) checkOutput("stall.out_high", 64'(result_stall_out), 64'd1);
      if (i == 5) checkOutput("stall.out_low", 64'(result_stall_out), 64'd0);
    end

    // Clear: a done window (held by window_full_in) survives a stream clear
    // and matches again against the next stream tuple
    seq_v[0] = mk(2'd0, 32'd0, '0, 1'b0, tup(50, 100), 1'b1, '0, 1'b0, '0, 3'd0, 16'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    seq_v[1] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b1, '0, 1'b0, '0, 3'd1, 16'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    seq_v[2] = mk(2'd0, 32'd0, '0, 1'b1, '0, 1'b1, '0, 1'b0, res(7, 50), 3'd0, 16'd12, 1'b1, 1'b1, 1'b0, 1'b1);
    seq_v[3] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b1, '0, 1'b0, '0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    seq_v[4] = mk(2'd0, 32'd0, tup(8, 100), 1'b0, '0, 1'b1, '0, 1'b0, '0, 3'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    seq_v[5] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b1, '0, 1'b0, '0, 3'd1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    seq_v[6] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b1, '0, 1'b0, res(8, 50), 3'd0, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    seq_v[7] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 3'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(seq_v[i]);
      checkVector($sformatf("clear%0d", i), seq_v[i]);
    end

    // Reset mid-operation with three entries queued behind upstream traffic
    seq_v[0] = mk(2'd0, 32'd0, '0, 1'b0, tup(90, 100), 1'b0, res(1, 2), 1'b0, res(1, 2), 3'd0, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    seq_v[1] = mk(2'd0, 32'd0, '0, 1'b0, tup(91, 100), 1'b0, res(3, 4), 1'b0, res(3, 4), 3'd1, 16'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    seq_v[2] = mk(2'd0, 32'd0, '0, 1'b0, tup(92, 100), 1'b0, res(5, 6), 1'b0, res(5, 6), 3'd2, 16'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    seq_v[3] = mk(2'd0, 32'd0, '0, 1'b0, '0, 1'b0, res(7, 8), 1'b0, res(7, 8), 3'd3, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(seq_v[i]);
      checkVector($sformatf("rst%0d", i), seq_v[i]);
    end
    idleInputs();
    #2;
    aresetn = 1'b0;
    #1;
    checkAllZero("rst.async");
    @(posedge aclk);
    #1;
    checkAllZero("rst.held");
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge aclk);
      #1;
      checkOutput($sformatf("rst.quiet%0d", c),
                  64'({result_pair_out, fifo_count}), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/join_core_stage_param.md
# join_core_stage_param

Parametrised successor to the single-tuple join core stage in the stream-join systolic chain. Holds one resident stream tuple and one passing window tuple, evaluates a configurable predicate (equi, band, less-than, disabled), and buffers matches in a local result FIFO. The FIFO drains into the result chain only when the upstream result slot is idle. Window flow is therefore decoupled from result-chain occupancy until the FIFO fills. Chains left/right with identical instances; the stream, window and result buses are daisy-chained.

## Interface
Parameters:
- KEY_WIDTH, 32, join key width
- ID_WIDTH, 31, tuple identifier width
- FIFO_DEPTH, 4, local result FIFO entries (power of two, ≥2)
- COUNT_WIDTH, 16, match counter width

Tuple formats:
- Stream/window tuple: {valid, id[ID_WIDTH], key[KEY_WIDTH]}, so TW = 1+ID_WIDTH+KEY_WIDTH.
- Result pair: {valid, stream_id, window_id}, so RW = 1+2·ID_WIDTH.

Ports. Clock and reset are one clock, `aclk`, plus `aresetn`, which is asynchronous and active-low.
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- mode_cfg  in  2  0 equi, 1 band, 2 less-than, 3 disabled
- band_cfg  in  KEY_WIDTH  band half-width
- stream_full_in  in  1  downstream stream stage full
- stream_full_out  out  1  this stream register valid
- stream_clear_in  in  1  clear request
- stream_clear_out  out  1  registered clear, forwarded
- stream_tuple_in  in  TW  upstream stream tuple
- stream_tuple_out  out  TW  resident stream tuple
- window_full_in  in  1  downstream window stage full
- window_full_out  out  1  window register valid
- window_tuple_in  in  TW  upstream window tuple
- window_tuple_out  out  TW  window tuple leaving this cycle (valid bit = flow)
- result_pair_in  in  RW  upstream result
- result_pair_out  out  RW  result register
- result_stall_in  in  1  downstream stall
- result_stall_out  out  1  registered stall
- fifo_count  out  log2(FIFO_DEPTH)+1  local FIFO occupancy
- match_count  out  COUNT_WIDTH  saturating enqueued-match count

## Operation
- **Stream register**
  - Cleared when clear_reg=1, or when it is valid and stream_full_in=0 (hand-off downstream).
  - Otherwise it loads stream_tuple_in when it is empty and the input is valid.
  - clear_reg is the one-cycle registered copy of stream_clear_in.
- **Window register**
  - Loads window_tuple_in when it is empty, or in the same cycle it flows out.
  - It is cleared when it flows out with no valid input.
  - Control flag done: the resident window tuple's result has already been enqueued.
- **Predicate**
  - match requires both registers valid and done=0, and mode_cfg≠3.
  - Equi: keys equal.
  - Band: unsigned |s.key−w.key| ≤ band_cfg; the difference is computed at KEY_WIDTH+1 bits.
  - Less-than: s.key < w.key, unsigned.
- **Enqueue**
  - push = match & fifo_count<FIFO_DEPTH.
  - Full is judged before the same-cycle pop; there is no bypass.
- **Flow**
  - flow = window valid & !window_full_in & (!match | push).
  - On push & !flow, done←1.
  - On flow, done←0.
  - clear_reg forces done←0, so the window tuple is re-evaluated against the new stream tuple.
- **Result register**
  - If result_pair_in is valid, it loads result_pair_in; upstream results are always forwarded.
  - Else, if the FIFO is non-empty and stall_reg=0, it pops the FIFO head.
  - Otherwise it loads 0.
- **Stall**
  - stall_reg ← result_stall_in; result_stall_out = stall_reg.
- **match_count**
  - Increments on push and saturates at all-ones.
  - Cleared by clear_reg.
- **Clear and the FIFO**
  - The FIFO is never flushed by clear; its results are already committed.

## Timing
- All registers, FIFO pointers, done, match_count, stall_reg and clear_reg reset to 0 asynchronously.
- Every output is 0 during reset.
- Stream tuple: input-to-stream_tuple_out takes 1 cycle; on hand-off it leaves 1 cycle later.
- Window tuple: resident ≥1 cycle; minimum latency from load to window_tuple_out valid is 1 cycle.
- Match to result_pair_out takes 2 edges (push, then pop) when the upstream result slot is idle and there is no stall.
- FIFO full:
  - A matching window tuple holds, window_full_out stays 1, and no duplicate is pushed.
  - It flows in the first cycle push succeeds.
- Already-enqueued tuple (done=1): flow depends only on window_full_in.
- Simultaneous pop and push on a full FIFO: no push; the push occurs next cycle.
- Reset asserted mid-operation: all in-flight tuples and FIFO contents are discarded with no output glitch beyond reset.

## Test plan
- Equi mode:
  - Stimulus: stream (id 5, key 0x10), window (id 9, key 0x10), downstream idle.
  - Required response: result_pair_out = {1,5,9} two cycles after the window load; match_count = 1.
- Band mode:
  - Stimulus: band_cfg=3, stream key 100, windows keys 97, 103, 104.
  - Required response: exactly 2 results, for 97 and 103; 104 produces none.
- FIFO full, FIFO_DEPTH=4:
  - Stimulus: hold result_pair_in valid for 10 cycles while 6 matching windows arrive.
  - Required response: fifo_count reaches 4 and the 5th window stalls. After upstream goes idle, 6 results emerge in order with no duplicates.
- Stall:
  - Stimulus: result_stall_in=1 for 3 cycles while the FIFO holds 2 entries.
  - Required response: no pop for 3 cycles, offset one cycle; upstream results are still forwarded.
- Clear:
  - Stimulus: assert stream_clear_in while a done window is resident, then load a new matching stream tuple.
  - Required response: stream_clear_out pulses 1 cycle, match_count=0, and the resident window produces a second result.
- Reset:
  - Stimulus: drop aresetn with the FIFO holding 3 entries.
  - Required response: all outputs 0 immediately; nothing is emitted after release.
